seq_bit_serializer: RTL and testbench

//   Parallel-to-serial front end for the "sequence" detector. Accepts a WIDTH-bit word

---
 rtl/seq_bit_serializer_if.sv | 24 ++
 rtl/seq_bit_serializer.sv | 128 ++++++++++++
 tb/tb_seq_bit_serializer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_bit_serializer_if.sv
// Load handshake, shift enable and serial outputs of the bit serializer.
interface seq_bit_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             shift_en;
    logic             x;
    logic             busy;
    logic             done;

    // Word source / detector side
    modport master (
        output load_valid, load_data, shift_en,
        input  load_ready, x, busy, done
    );

    // Serializer side
    modport slave (
        input  load_valid, load_data, shift_en,
        output load_ready, x, busy, done
    );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: takes WIDTH-bit words over valid/ready and
// drives them one bit per enabled clock onto x, with zero gap between words.
module seq_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input logic                 clk,
    input logic                 rst,
    seq_bit_serializer_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_x;
    logic             w_x_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_ready;
    logic [WIDTH-1:0] w_shifted;

    // Bit that leaves first from a given word
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Shift register contents after consuming the current bit
    always_comb begin
        if (MSB_FIRST) begin
            w_shifted = {r_sreg[WIDTH-2:0], 1'b0};
        end else begin
            w_shifted = {1'b0, r_sreg[WIDTH-1:1]};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_x    <= IDLE_BIT;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_sreg <= w_sreg_nxt;
            r_cnt  <= w_cnt_nxt;
            r_x    <= w_x_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Next-state, next-datapath and combinational ready
    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_cnt_nxt   = r_cnt;
        w_x_nxt     = r_x;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_ready     = 1'b0;

        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.load_valid) begin
                    w_sreg_nxt  = bus.load_data;
                    w_cnt_nxt   = CW'(WIDTH - 1);
                    w_x_nxt     = first_bit(bus.load_data);
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // Only the last bit may overlap with accepting the next word
                w_ready = (r_cnt == '0) && bus.shift_en;
                if (bus.shift_en) begin
                    if (r_cnt != '0) begin
                        w_sreg_nxt = w_shifted;
                        w_cnt_nxt  = r_cnt - CW'(1);
                        w_x_nxt    = first_bit(w_shifted);
                    end else begin
                        w_done_nxt = 1'b1;
                        if (bus.load_valid) begin
                            w_sreg_nxt = bus.load_data;
                            w_cnt_nxt  = CW'(WIDTH - 1);
                            w_x_nxt    = first_bit(bus.load_data);
                        end else begin
                            w_sreg_nxt  = '0;
                            w_x_nxt     = IDLE_BIT;
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.load_ready = w_ready;
    assign bus.x          = r_x;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: an MSB-first and an LSB-first instance see the
// same stimulus; a per-instance bit queue predicts ready, x, busy and done.
module tb_seq_bit_serializer;
    logic       clk;
    logic       rst;
    logic       tb_valid;
    logic [7:0] tb_data;
    logic       tb_se;

    int n_chk;
    int n_err;

    seq_bit_serializer_if #(.WIDTH(8)) if0 ();
    seq_bit_serializer_if #(.WIDTH(8)) if1 ();

    assign if0.load_valid = tb_valid;
    assign if0.load_data  = tb_data;
    assign if0.shift_en   = tb_se;
    assign if1.load_valid = tb_valid;
    assign if1.load_data  = tb_data;
    assign if1.shift_en   = tb_se;

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: bits of accepted words in output order, per instance
    bit m_q0[$];
    bit m_q1[$];
    int m_left[2];
    bit m_busy[2];
    bit m_done[2];

    function automatic void model_clear();
        m_q0.delete();
        m_q1.delete();
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0;
            m_busy[k] = 1'b0;
            m_done[k] = 1'b0;
        end
    endfunction

    function automatic logic model_ready(input int k, input logic se);
        return !m_busy[k] || (m_left[k] == 1 && se);
    endfunction

    function automatic logic model_x(input int k);
        if (!m_busy[k]) return 1'b0;
        return (k == 0) ? m_q0[0] : m_q1[0];
    endfunction

    // Advance one instance's scoreboard across a clock edge
    function automatic void model_edge(input int k, input logic v, input logic [7:0] d,
                                       input logic se);
        logic rdy;
        rdy       = model_ready(k, se);
        m_done[k] = 1'b0;
        if (m_busy[k] && se) begin
            if (k == 0) void'(m_q0.pop_front());
            else        void'(m_q1.pop_front());
            m_left[k]--;
            if (m_left[k] == 0) begin
                m_done[k] = 1'b1;
                m_busy[k] = 1'b0;
            end
        end
        if (v && rdy) begin
            for (int i = 0; i < 8; i++) begin
                if (k == 0) m_q0.push_back(d[7-i]);
                else        m_q1.push_back(d[i]);
            end
            m_left[k] = 8;
            m_busy[k] = 1'b1;
        end
    endfunction

    // One clock: drive inputs, capture ready, clock, capture registered outputs
    task automatic step(input logic v, input logic [7:0] d, input logic se,
                        output logic rdy, output logic [7:0] obs, output logic [7:0] exp);
        logic r0;
        logic r1;
        logic e0;
        logic e1;
        tb_valid = v;
        tb_data  = d;
        tb_se    = se;
        #1;
        r0 = if0.load_ready;
        r1 = if1.load_ready;
        e0 = model_ready(0, se);
        e1 = model_ready(1, se);
        rdy = e0;
        model_edge(0, v, d, se);
        model_edge(1, v, d, se);
        @(posedge clk);
        #1;
        obs = {r0, r1, if0.x, if0.busy, if0.done, if1.x, if1.busy, if1.done};
        exp = {e0, e1, model_x(0), m_busy[0], m_done[0], model_x(1), m_busy[1], m_done[1]};
    endtask

    task automatic test_reset();
        tb_valid = 1'b0;
        tb_data  = '0;
        tb_se    = 1'b0;
        rst      = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            tb_valid = 1'($urandom);
            tb_data  = 8'($urandom);
            tb_se    = 1'($urandom);
            #7;
            n_chk++;
            if ({if0.x, if0.busy, if0.done, if1.x, if1.busy, if1.done} !== 6'b0) begin
                n_err++;
                $display("FAIL reset_hold i=%0d got=%b want=000000", i,
                         {if0.x, if0.busy, if0.done, if1.x, if1.busy, if1.done});
            end
        end
        tb_valid = 1'b0;
        tb_se    = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({if0.load_ready, if1.load_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_ready got=%b want=11", {if0.load_ready, if1.load_ready});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic rdy;
        logic [7:0] obs;
        logic [7:0] exp;
        for (int i = 0; i < 11; i++) begin
            step(i == 0, (i == 0) ? 8'hB4 : 8'($urandom), 1'b1, rdy, obs, exp);
            n_chk++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL single cyc=%0d got=%b want=%b", i, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic rdy;
        logic [7:0] obs;
        logic [7:0] exp;
        for (int i = 0; i < 19; i++) begin
            step(i == 0 || (i >= 4 && i <= 8), (i == 0) ? 8'hB4 : 8'h0F, 1'b1, rdy, obs, exp);
            n_chk++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL back_to_back cyc=%0d got=%b want=%b", i, obs, exp);
            end
        end
    endtask

    task automatic test_stall();
        logic rdy;
        logic [7:0] obs;
        logic [7:0] exp;
        for (int i = 0; i < 14; i++) begin
            step(i == 0, 8'hB4, !(i >= 2 && i <= 4), rdy, obs, exp);
            n_chk++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL stall cyc=%0d got=%b want=%b", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_midword();
        logic rdy;
        logic [7:0] obs;
        logic [7:0] exp;
        for (int i = 0; i < 3; i++) begin
            step(i == 0, 8'hB4, 1'b1, rdy, obs, exp);
            n_chk++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL midrst_pre cyc=%0d got=%b want=%b", i, obs, exp);
            end
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if ({if0.x, if0.busy, if0.done, if1.x, if1.busy, if1.done} !== 6'b0) begin
            n_err++;
            $display("FAIL midrst_async got=%b want=000000",
                     {if0.x, if0.busy, if0.done, if1.x, if1.busy, if1.done});
        end
        model_clear();
        @(posedge clk);
        #1;
        n_chk++;
        if ({if0.done, if1.done, if0.busy, if1.busy} !== 4'b0) begin
            n_err++;
            $display("FAIL midrst_nodone got=%b want=0000",
                     {if0.done, if1.done, if0.busy, if1.busy});
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(i == 0, 8'hFF, 1'b1, rdy, obs, exp);
            n_chk++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL midrst_post cyc=%0d got=%b want=%b", i, obs, exp);
            end
        end
    endtask

    task automatic test_ignore_midword();
        logic rdy;
        logic [7:0] obs;
        logic [7:0] exp;
        for (int i = 0; i < 11; i++) begin
            step(i == 0 || i == 3 || i == 4, (i == 0) ? 8'hB4 : 8'h3C, 1'b1, rdy, obs, exp);
            n_chk++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL ignore_mid cyc=%0d got=%b want=%b", i, obs, exp);
            end
        end
    endtask

    task automatic test_random();
        logic rdy;
        logic [7:0] obs;
        logic [7:0] exp;
        logic pend;
        logic [7:0] pd;
        pend = 1'b0;
        pd   = '0;
        for (int i = 0; i < 120; i++) begin
            if (!pend && $urandom_range(0, 2) != 0) begin
                pend = 1'b1;
                pd   = 8'($urandom);
            end
            step(pend, pend ? pd : 8'($urandom), $urandom_range(0, 3) != 0, rdy, obs, exp);
            if (pend && rdy) pend = 1'b0;
            n_chk++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, obs, exp);
            end
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 8'h00, 1'b1, rdy, obs, exp);
            n_chk++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL drain cyc=%0d got=%b want=%b", i, obs, exp);
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_midword();
        test_ignore_midword();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
